// File: rtl/prescaler_pkg.sv
// -----------------------------------------------------------------------------
// prescaler_pkg
// Shared constants and helper functions for the prescaler bank.
//   - DEF_* : default parameter values for prescaler_bank
//   - link_cnt_t : link hold counter type (covers the full 1..65535 ms range)
//   - ms_divisor() : oscillator cycles per millisecond
//   - freq_word()  : rounded phase-accumulator increment for a target rate
// Optional feature macro used by the bank: PRESCALER_PHASE_SYNC_EN
// -----------------------------------------------------------------------------
package prescaler_pkg;

  localparam int DEF_OSCRATE       = 12_000_000;
  localparam int DEF_NUM_CH        = 3;
  localparam int DEF_ACC_W         = 24;
  localparam int DEF_BLINK_HALF_MS = 500;
  localparam int DEF_LINK_HOLD_MS  = 64;

  localparam int LINK_CNT_W = 16;
  typedef logic [LINK_CNT_W-1:0] link_cnt_t;

  // Oscillator cycles in one millisecond.
  function automatic int unsigned ms_divisor(input int unsigned oscrate);
    return oscrate / 1000;
  endfunction

  // Frequency word giving an average tick rate of `rate` Hz:
  // round(rate * 2^acc_w / oscrate). Intended for elaboration-time use by
  // integrators and benches; the 64-bit intermediate covers practical rates.
  function automatic longint unsigned freq_word(input longint unsigned rate,
                                                input longint unsigned oscrate,
                                                input int unsigned     acc_w);
    longint unsigned scaled;
    scaled = rate << acc_w;
    return (scaled + (oscrate >> 1)) / oscrate;
  endfunction

endpackage : prescaler_pkg

// File: rtl/prescaler_bank_phase_acc.sv
// -----------------------------------------------------------------------------
// phase_acc
// One fractional clock channel: a phase accumulator advanced by a runtime
// frequency word every cycle while enabled.
// Ports:
//   clk       in   oscillator clock
//   rst_n     in   asynchronous active-low reset
//   enable    in   run enable; low clears the channel on the next edge
//   incr      in   ACC_W-bit frequency word
//   sync_req  in   (PRESCALER_PHASE_SYNC_EN only) clear phase on this edge
//   tick      out  one-cycle pulse on accumulator carry-out
//   clk_out   out  accumulator MSB, registered alongside the accumulator
// Optional feature macro: PRESCALER_PHASE_SYNC_EN
// -----------------------------------------------------------------------------
module phase_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] incr,
`ifdef PRESCALER_PHASE_SYNC_EN
  input  logic             sync_req,
`endif
  output logic             tick,
  output logic             clk_out
);

  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             tick_q,  tick_d;
  logic             clk_out_q, clk_out_d;
  logic [ACC_W:0]   sum;
  logic             clear;

  // One extra bit on the add gives the carry that becomes the tick.
  assign sum = {1'b0, acc_q} + {1'b0, incr};

`ifdef PRESCALER_PHASE_SYNC_EN
  // A sync pulse takes priority over the add so all channels restart at
  // phase 0 together.
  assign clear = ~enable | sync_req;
`else
  assign clear = ~enable;
`endif

  always_comb begin
    acc_d     = sum[ACC_W-1:0];
    tick_d    = sum[ACC_W];
    clk_out_d = sum[ACC_W-1];
    if (clear) begin
      acc_d     = '0;
      tick_d    = 1'b0;
      clk_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;

endmodule : phase_acc

// File: rtl/prescaler_bank.sv
// -----------------------------------------------------------------------------
// prescaler_bank
// NUM_CH independent fractional clock channels plus millisecond-based status
// outputs (blink LED toggle and serial activity indicator).
// Ports:
//   clk       in   oscillator clock, all logic on rising edge
//   rst_n     in   asynchronous active-low reset
//   enable    in   [NUM_CH]        per-channel run enable
//   incr      in   [NUM_CH*ACC_W]  frequency words, channel i at [i*ACC_W +: ACC_W]
//   rx        in   asynchronous serial line (activity detection only)
//   sync_req  in   (PRESCALER_PHASE_SYNC_EN only) phase-align all channels
//   tick      out  [NUM_CH] one-cycle pulse per accumulator overflow
//   clk_out   out  [NUM_CH] near-50 % square clock (registered accumulator MSB)
//   blink     out  toggles every BLINK_HALF_MS milliseconds
//   link      out  high for LINK_HOLD_MS ms after the last rx edge
// Optional feature macro: PRESCALER_PHASE_SYNC_EN
// -----------------------------------------------------------------------------
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int OSCRATE       = DEF_OSCRATE,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int BLINK_HALF_MS = DEF_BLINK_HALF_MS,
  parameter int LINK_HOLD_MS  = DEF_LINK_HOLD_MS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*ACC_W-1:0] incr,
  input  logic                    rx,
`ifdef PRESCALER_PHASE_SYNC_EN
  input  logic                    sync_req,
`endif
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    blink,
  output logic                    link
);

  // ---------------------------------------------------------------------------
  // Counter geometry
  // ---------------------------------------------------------------------------
  localparam int unsigned MS_DIV = ms_divisor(OSCRATE);
  localparam int MS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int BLINK_W = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;

  localparam logic [MS_W-1:0]    MS_RELOAD    = MS_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]    MS_ONE       = MS_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_HALF_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE    = BLINK_W'(1);
  localparam link_cnt_t          LINK_RELOAD  = link_cnt_t'(LINK_HOLD_MS);
  localparam link_cnt_t          LINK_ONE     = link_cnt_t'(1);

  // ---------------------------------------------------------------------------
  // Phase-accumulator channels
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      phase_acc #(
        .ACC_W (ACC_W)
      ) u_phase_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable[gi]),
        .incr     (incr[gi*ACC_W +: ACC_W]),
`ifdef PRESCALER_PHASE_SYNC_EN
        .sync_req (sync_req),
`endif
        .tick     (tick[gi]),
        .clk_out  (clk_out[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Millisecond timebase
  // ---------------------------------------------------------------------------
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic            ms_tick;

  // ms_tick is the cycle in which the down-counter sits at zero, so it
  // repeats every MS_DIV cycles.
  assign ms_tick  = (ms_cnt_q == '0);
  assign ms_cnt_d = ms_tick ? MS_RELOAD : (ms_cnt_q - MS_ONE);

  // ---------------------------------------------------------------------------
  // Blink
  // ---------------------------------------------------------------------------
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q,     blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (ms_tick) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_d = BLINK_RELOAD;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q - BLINK_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // rx activity detection
  // ---------------------------------------------------------------------------
  // Two synchroniser stages plus one delay stage; all preset to the idle
  // (high) line level so reset release does not fake an edge.
  logic      rx_meta_q, rx_sync_q, rx_dly_q;
  logic      rx_edge;
  link_cnt_t link_cnt_q, link_cnt_d;
  logic      link_q,     link_d;

  assign rx_edge = rx_sync_q ^ rx_dly_q;

  always_comb begin
    link_cnt_d = link_cnt_q;
    // A fresh edge reloads even when it lands on an ms_tick.
    if (rx_edge) begin
      link_cnt_d = LINK_RELOAD;
    end else if (ms_tick && (link_cnt_q != '0)) begin
      link_cnt_d = link_cnt_q - LINK_ONE;
    end
  end

  assign link_d = (link_cnt_q != '0);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt_q    <= MS_RELOAD;
      blink_cnt_q <= BLINK_RELOAD;
      blink_q     <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_dly_q    <= 1'b1;
      link_cnt_q  <= '0;
      link_q      <= 1'b0;
    end else begin
      ms_cnt_q    <= ms_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_dly_q    <= rx_sync_q;
      link_cnt_q  <= link_cnt_d;
      link_q      <= link_d;
    end
  end

  assign blink = blink_q;
  assign link  = link_q;

endmodule : prescaler_bank
